// File: rtl/cpu_sb_drain.sv
// Store-buffer drain controller: pops the oldest buffered store and commits it into a
// direct-mapped cache, evicting/filling on a miss. Optional macro: SB_DRAIN_FILL_MERGE_EN.
module cpu_sb_drain #(
    parameter int TAG_WIDTH     = 32,
    parameter int BYTES_IN_DATA = 4,
    parameter int NUM_LINES     = 4,
    parameter int BYTES_IN_LINE = 16,
    localparam int IDX  = $clog2(NUM_LINES),
    localparam int OFF  = $clog2(BYTES_IN_LINE),
    localparam int BO   = $clog2(BYTES_IN_DATA),
    localparam int WSEL = OFF - BO,
    localparam int CT   = TAG_WIDTH - IDX - OFF,
    localparam int DW   = BYTES_IN_DATA * 8,
    localparam int LW   = BYTES_IN_LINE * 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     drain_stall,
    input  logic                     sb_empty,
    input  logic [TAG_WIDTH-1:0]     sb_tag,
    input  logic [BYTES_IN_DATA-1:0] sb_bytes,
    input  logic [DW-1:0]            sb_data,
    output logic                     sb_pop,
    output logic [IDX-1:0]           cache_index,
    input  logic                     cache_hit,
    input  logic                     cache_valid,
    input  logic                     cache_dirty,
    input  logic [CT-1:0]            cache_vtag,
    input  logic [LW-1:0]            cache_rline,
    output logic [CT-1:0]            cache_lookup_tag,
    output logic                     cache_we,
    output logic [WSEL-1:0]          cache_word,
    output logic [BYTES_IN_DATA-1:0] cache_byte_en,
    output logic [DW-1:0]            cache_wdata,
    output logic                     fill_we,
    output logic [LW-1:0]            fill_line,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [TAG_WIDTH-1:0]     mem_addr,
    output logic [LW-1:0]            mem_wline,
    input  logic [LW-1:0]            mem_rline,
    input  logic                     mem_ack,
    output logic                     busy
);
    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, WRITE} state_t;

    state_t                   state_q, state_d;
    logic [TAG_WIDTH-1:BO]    tag_q, tag_d;
    logic [BYTES_IN_DATA-1:0] bytes_q, bytes_d;
    logic [DW-1:0]            data_q, data_d;
    logic [TAG_WIDTH-1:0]     vaddr_q, vaddr_d;
    logic [LW-1:0]            vline_q, vline_d;

    // Store addresses are word aligned; the byte-offset bits carry no information.
    logic unused_tag_lo;
    assign unused_tag_lo = ^sb_tag[BO-1:0];

`ifdef SB_DRAIN_FILL_MERGE_EN
    function automatic logic [LW-1:0] merge_word(input logic [LW-1:0]            line,
                                                 input logic [WSEL-1:0]          word,
                                                 input logic [BYTES_IN_DATA-1:0] be,
                                                 input logic [DW-1:0]            data);
        logic [LW-1:0] merged;
        merged = line;
        for (int b = 0; b < BYTES_IN_DATA; b++) begin
            if (be[b]) begin
                merged[int'(word) * DW + b * 8 +: 8] = data[b * 8 +: 8];
            end
        end
        return merged;
    endfunction
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        bytes_d          = bytes_q;
        data_d           = data_q;
        vaddr_d          = vaddr_q;
        vline_d          = vline_q;
        sb_pop           = 1'b0;
        cache_index      = '0;
        cache_lookup_tag = '0;
        cache_we         = 1'b0;
        cache_word       = '0;
        cache_byte_en    = '0;
        cache_wdata      = '0;
        fill_we          = 1'b0;
        fill_line        = '0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wline        = '0;

        // The latched line index stays on the array port for the whole drain so fills land on it.
        if (state_q != IDLE) begin
            cache_index      = tag_q[OFF +: IDX];
            cache_lookup_tag = tag_q[TAG_WIDTH-1 -: CT];
        end

        case (state_q)
            IDLE: begin
                if (!sb_empty && !drain_stall) begin
                    tag_d   = sb_tag[TAG_WIDTH-1:BO];
                    bytes_d = sb_bytes;
                    data_d  = sb_data;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit) begin
                    state_d = WRITE;
                end else if (cache_valid && cache_dirty) begin
                    vaddr_d = {cache_vtag, tag_q[OFF +: IDX], {OFF{1'b0}}};
                    vline_d = cache_rline;
                    state_d = EVICT;
                end else begin
                    state_d = FILL;
                end
            end
            EVICT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = vaddr_q;
                mem_wline = vline_q;
                if (mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q[TAG_WIDTH-1:OFF], {OFF{1'b0}}};
                if (mem_ack) begin
                    fill_we = 1'b1;
`ifdef SB_DRAIN_FILL_MERGE_EN
                    // Store folded into the installed line; the cache marks it dirty on this fill.
                    fill_line = merge_word(mem_rline, tag_q[OFF-1 -: WSEL], bytes_q, data_q);
                    sb_pop    = !sb_empty;
                    state_d   = IDLE;
`else
                    fill_line = mem_rline;
                    state_d   = WRITE;
`endif
                end
            end
            WRITE: begin
                cache_we      = 1'b1;
                cache_word    = tag_q[OFF-1 -: WSEL];
                cache_byte_en = bytes_q;
                cache_wdata   = data_q;
                sb_pop        = !sb_empty;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
        tag_q   <= tag_d;
        bytes_q <= bytes_d;
        data_q  <= data_d;
        vaddr_q <= vaddr_d;
        vline_q <= vline_d;
    end

`ifndef SYNTHESIS
    sb_empty_rise_in_flight: assert property (@(posedge clock) disable iff (reset)
        (state_q != IDLE) |-> !$rose(sb_empty))
        else $error("cpu_sb_drain: store buffer emptied while a drain was in flight");
`endif
endmodule
